// File: rtl/decode_queue_stage_if.sv
// Fetch-to-EX handshake bundle for the decode queue stage: instruction input
// side, registered decode bundle output side and queue occupancy.
interface decode_queue_stage_if #(
    parameter int W     = 32,
    parameter int CNT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_inst;
    logic [W-1:0]     in_pc;

    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_pc;
    logic [1:0]       out_inst_type;
    logic [5:0]       out_op_code;
    logic [5:0]       out_funct;
    logic [4:0]       out_rs;
    logic [4:0]       out_rt;
    logic [4:0]       out_rd;
    logic [4:0]       out_shamt;
    logic [W-1:0]     out_imm;
    logic [25:0]      out_j_addr;
    logic             out_illegal;
    logic [CNT_W-1:0] occupancy;

    // Drives fetch instructions and the EX ready.
    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_inst_type, out_op_code, out_funct,
               out_rs, out_rt, out_rd, out_shamt, out_imm, out_j_addr, out_illegal,
               occupancy
    );

    // The decode queue stage itself.
    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_inst_type, out_op_code, out_funct,
               out_rs, out_rt, out_rd, out_shamt, out_imm, out_j_addr, out_illegal,
               occupancy
    );
endinterface

// File: rtl/decode_queue_stage.sv
// MIPS32 decode stage: a DEPTH-entry instruction FIFO feeding a registered
// decode bundle, with bypass on an empty queue, back-pressure and flush.
module decode_queue_stage #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    decode_queue_stage_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    typedef enum logic [1:0] {
        TYPE_R = 2'b00,
        TYPE_I = 2'b01,
        TYPE_J = 2'b10
    } inst_type_e;

    typedef struct packed {
        logic [W-1:0] pc;
        logic [W-1:0] inst;
    } entry_t;

    typedef struct packed {
        logic [W-1:0] pc;
        inst_type_e   inst_type;
        logic [5:0]   op_code;
        logic [5:0]   funct;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [4:0]   rd;
        logic [4:0]   shamt;
        logic [W-1:0] imm;
        logic [25:0]  j_addr;
        logic         illegal;
    } bundle_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_empty;
    logic             accept;
    logic             load;
    logic             pop;
    logic             bypass;
    logic             push;
    entry_t           src;
    bundle_t          dec;
    bundle_t          out_q;
    logic             out_valid_q;

    assign fifo_empty    = (count == '0);
    assign bus.in_ready  = (count < CNT_W'(DEPTH));
    assign bus.occupancy = count;

    // The FIFO head always outranks a new input, which keeps program order;
    // a new input only bypasses the FIFO when it is empty and the output loads.
    assign accept = bus.in_valid && bus.in_ready && !flush;
    assign load   = !out_valid_q || bus.out_ready;
    assign pop    = load && !fifo_empty && !flush;
    assign bypass = load && fifo_empty && accept;
    assign push   = accept && !bypass;
    assign src    = pop ? mem[rd_ptr] : entry_t'{pc: bus.in_pc, inst: bus.in_inst};

    // NOTE: the storage array has no reset; entries are only read once the
    // occupancy count says they were written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry_t'{pc: bus.in_pc, inst: bus.in_inst};
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: every field gets a default before the case so no latch is inferred.
    always_comb begin
        logic [5:0] op;
        logic       is_r;
        logic       is_j;
        op          = src.inst[31:26];
        is_r        = (op == OP_RTYPE);
        is_j        = (op == OP_J) || (op == OP_JAL);
        dec         = '0;
        dec.pc      = src.pc;
        dec.op_code = op;
        dec.illegal = 1'b0;
        dec.inst_type = is_r ? TYPE_R : (is_j ? TYPE_J : TYPE_I);
        dec.funct   = is_r ? src.inst[5:0]   : 6'd0;
        dec.rd      = is_r ? src.inst[15:11] : 5'd0;
        dec.shamt   = is_r ? src.inst[10:6]  : 5'd0;
        dec.rs      = is_j ? 5'd0 : src.inst[25:21];
        dec.rt      = is_j ? 5'd0 : src.inst[20:16];
        dec.j_addr  = is_j ? src.inst[25:0] : 26'd0;
        case (op)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW,
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM:
                dec.imm = {{(W-16){src.inst[15]}}, src.inst[15:0]};
            OP_ANDI, OP_ORI, OP_XORI:
                dec.imm = {{(W-16){1'b0}}, src.inst[15:0]};
            OP_LUI:
                dec.imm = W'({src.inst[15:0], 16'h0000});
            OP_RTYPE, OP_J, OP_JAL:
                dec.imm = '0;
            default: begin
                dec.imm     = '0;
                dec.illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (load) begin
            out_valid_q <= pop || bypass;
            if (pop || bypass) out_q <= dec;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_pc        = out_q.pc;
    assign bus.out_inst_type = out_q.inst_type;
    assign bus.out_op_code   = out_q.op_code;
    assign bus.out_funct     = out_q.funct;
    assign bus.out_rs        = out_q.rs;
    assign bus.out_rt        = out_q.rt;
    assign bus.out_rd        = out_q.rd;
    assign bus.out_shamt     = out_q.shamt;
    assign bus.out_imm       = out_q.imm;
    assign bus.out_j_addr    = out_q.j_addr;
    assign bus.out_illegal   = out_q.illegal;
endmodule

// File: tb/tb_decode_queue_stage.sv
// Bench for decode_queue_stage: directed scenarios plus random traffic, checked
// against a queue of in-flight instructions and a table-driven decode model.
module tb_decode_queue_stage;
    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  typ;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic [25:0] j_addr;
        logic        illegal;
    } bundle_t;

    typedef struct packed {
        logic       valid;
        logic       in_ready;
        logic [2:0] occ;
    } status_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    int   errors = 0;
    int   checks = 0;
    item_t pending[$];

    always #5 clk = ~clk;

    decode_queue_stage_if #(.W(W), .CNT_W(CNT_W)) bus ();

    decode_queue_stage #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus)
    );

    // Decode straight from the opcode tables of the MIPS32 subset.
    function automatic bundle_t ref_decode(item_t it);
        bundle_t     b;
        logic [5:0]  op;
        logic        is_r, is_j, sx, zx, lui;
        op   = it.inst[31:26];
        is_r = (op == 6'd0);
        is_j = (op == 6'd2) || (op == 6'd3);
        sx   = op inside {6'd8, 6'd9, 6'd10, 6'd11, 6'd35, 6'd43, 6'd4, 6'd5, 6'd6, 6'd7, 6'd1};
        zx   = op inside {6'd12, 6'd13, 6'd14};
        lui  = (op == 6'd15);
        b.pc      = it.pc;
        b.op      = op;
        b.typ     = is_r ? 2'b00 : (is_j ? 2'b10 : 2'b01);
        b.funct   = is_r ? it.inst[5:0] : 6'd0;
        b.rd      = is_r ? it.inst[15:11] : 5'd0;
        b.shamt   = is_r ? it.inst[10:6] : 5'd0;
        b.rs      = is_j ? 5'd0 : it.inst[25:21];
        b.rt      = is_j ? 5'd0 : it.inst[20:16];
        b.j_addr  = is_j ? it.inst[25:0] : 26'd0;
        b.imm     = sx  ? 32'($signed(it.inst[15:0])) :
                    zx  ? {16'd0, it.inst[15:0]} :
                    lui ? {it.inst[15:0], 16'd0} : 32'd0;
        b.illegal = !(is_r || is_j || sx || zx || lui);
        return b;
    endfunction

    function automatic int model_occ();
        return (pending.size() > 0) ? pending.size() - 1 : 0;
    endfunction

    function automatic status_t exp_status();
        status_t s;
        s.valid    = (pending.size() > 0);
        s.occ      = 3'(model_occ());
        s.in_ready = (model_occ() < DEPTH);
        return s;
    endfunction

    function automatic status_t dut_status();
        status_t s;
        s.valid    = bus.out_valid;
        s.occ      = bus.occupancy;
        s.in_ready = bus.in_ready;
        return s;
    endfunction

    function automatic bundle_t dut_bundle();
        bundle_t b;
        b.pc = bus.out_pc;       b.typ = bus.out_inst_type; b.op = bus.out_op_code;
        b.funct = bus.out_funct; b.rs = bus.out_rs;         b.rt = bus.out_rt;
        b.rd = bus.out_rd;       b.shamt = bus.out_shamt;   b.imm = bus.out_imm;
        b.j_addr = bus.out_j_addr; b.illegal = bus.out_illegal;
        return b;
    endfunction

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.in_inst   = inst;
        bus.in_pc     = pc;
        bus.out_ready = rdy;
        flush         = fl;
    endtask

    // Advance one edge and apply the same edge to the reference queue.
    task automatic tick();
        bit acc, deliver;
        item_t it;
        acc     = bus.in_valid && (model_occ() < DEPTH);
        deliver = (pending.size() > 0) && bus.out_ready;
        it.pc   = bus.in_pc;
        it.inst = bus.in_inst;
        @(posedge clk);
        if (flush) begin
            pending.delete();
        end else begin
            if (deliver) void'(pending.pop_front());
            if (acc) pending.push_back(it);
        end
        #1;
    endtask

    task automatic drain();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (DEPTH + 2) tick();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0] ops [20] = '{6'd0, 6'd2, 6'd3, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13,
                                 6'd14, 6'd15, 6'd35, 6'd43, 6'd4, 6'd5, 6'd6, 6'd7, 6'd1,
                                 6'd63, 6'd20};
        logic [5:0] op;
        op = ops[$urandom_range(19)];
        if ($urandom_range(9) == 0) op = 6'($urandom);
        return {op, 26'($urandom)};
    endfunction

    task automatic test_reset();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        #12;
        checks++;
        if (dut_status() !== status_t'{valid: 1'b0, in_ready: 1'b1, occ: 3'd0}) begin
            errors++;
            $display("FAIL reset_status got %h want %h", dut_status(), status_t'{valid: 1'b0, in_ready: 1'b1, occ: 3'd0});
        end
        checks++;
        if (dut_bundle() !== bundle_t'('0)) begin
            errors++;
            $display("FAIL reset_payload got %h want 0", dut_bundle());
        end
        rst = 1'b1;
        pending.delete();
    endtask

    task automatic test_single_push();
        bundle_t want;
        want = '{pc: 32'h100, typ: 2'b01, op: 6'h08, funct: 6'd0, rs: 5'd0, rt: 5'd8, rd: 5'd0,
                 shamt: 5'd0, imm: 32'hFFFF_FFFF, j_addr: 26'd0, illegal: 1'b0};
        drive(1'b1, 32'h2008_FFFF, 32'h100, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (dut_status() !== status_t'{valid: 1'b1, in_ready: 1'b1, occ: 3'd0}) begin
            errors++;
            $display("FAIL single_status got %h want %h", dut_status(), status_t'{valid: 1'b1, in_ready: 1'b1, occ: 3'd0});
        end
        checks++;
        if (dut_bundle() !== want) begin
            errors++;
            $display("FAIL single_addi got %h want %h", dut_bundle(), want);
        end
        drain();
    endtask

    task automatic test_imm_ext();
        logic [31:0] insts [3] = '{32'h3508_FFFF, 32'h3C01_1234, 32'h0800_0040};
        bundle_t     want  [3];
        want[0] = '{pc: 32'h200, typ: 2'b01, op: 6'h0D, funct: 6'd0, rs: 5'd8, rt: 5'd8, rd: 5'd0,
                    shamt: 5'd0, imm: 32'h0000_FFFF, j_addr: 26'd0, illegal: 1'b0};
        want[1] = '{pc: 32'h204, typ: 2'b01, op: 6'h0F, funct: 6'd0, rs: 5'd0, rt: 5'd1, rd: 5'd0,
                    shamt: 5'd0, imm: 32'h1234_0000, j_addr: 26'd0, illegal: 1'b0};
        want[2] = '{pc: 32'h208, typ: 2'b10, op: 6'h02, funct: 6'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0,
                    shamt: 5'd0, imm: 32'd0, j_addr: 26'h40, illegal: 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, insts[i], 32'h200 + 32'(4 * i), 1'b1, 1'b0);
            tick();
            checks++;
            if (!bus.out_valid || dut_bundle() !== want[i]) begin
                errors++;
                $display("FAIL imm_ext[%0d] valid=%b got %h want %h", i, bus.out_valid, dut_bundle(), want[i]);
            end
        end
        drain();
    endtask

    task automatic test_back_pressure();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h2000_0000 | 32'(i), 32'h300 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (dut_status() !== status_t'{valid: 1'b1, in_ready: 1'b0, occ: 3'd4} || bus.out_pc !== 32'h300) begin
            errors++;
            $display("FAIL full_stall got %h pc=%h want %h pc=300", dut_status(), bus.out_pc, status_t'{valid: 1'b1, in_ready: 1'b0, occ: 3'd4});
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (!bus.out_valid || bus.out_pc !== 32'h300 + 32'(4 * i) || dut_bundle() !== ref_decode(pending[0])) begin
                errors++;
                $display("FAIL release[%0d] valid=%b pc=%h want pc=%h", i, bus.out_valid, bus.out_pc, 32'h300 + 32'(4 * i));
            end
            tick();
        end
        checks++;
        if (dut_status() !== exp_status()) begin
            errors++;
            $display("FAIL release_empty got %h want %h", dut_status(), exp_status());
        end
    endtask

    task automatic test_push_pop_wrap();
        logic [31:0] pc;
        pc = 32'h400;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rand_inst(), pc, 1'b0, 1'b0);
            tick();
            pc += 4;
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, rand_inst(), pc, 1'b1, 1'b0);
            tick();
            pc += 4;
            checks++;
            if (bus.occupancy !== 3'd2 || bus.out_pc !== 32'h404 + 32'(4 * i) ||
                dut_status() !== exp_status() || dut_bundle() !== ref_decode(pending[0])) begin
                errors++;
                $display("FAIL wrap[%0d] occ=%0d pc=%h want occ=2 pc=%h", i, bus.occupancy, bus.out_pc, 32'h404 + 32'(4 * i));
            end
        end
        drain();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, rand_inst(), 32'h500 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        checks++;
        if (dut_status() !== status_t'{valid: 1'b1, in_ready: 1'b1, occ: 3'd3}) begin
            errors++;
            $display("FAIL pre_flush got %h want %h", dut_status(), status_t'{valid: 1'b1, in_ready: 1'b1, occ: 3'd3});
        end
        drive(1'b1, 32'h2000_0001, 32'h5FC, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (dut_status() !== status_t'{valid: 1'b0, in_ready: 1'b1, occ: 3'd0}) begin
            errors++;
            $display("FAIL post_flush got %h want %h", dut_status(), status_t'{valid: 1'b0, in_ready: 1'b1, occ: 3'd0});
        end
        drive(1'b1, 32'h2402_0007, 32'h600, 1'b1, 1'b0);
        tick();
        checks++;
        if (!bus.out_valid || bus.out_pc !== 32'h600 || bus.occupancy !== 3'd0) begin
            errors++;
            $display("FAIL flush_next valid=%b pc=%h occ=%0d want 1 600 0", bus.out_valid, bus.out_pc, bus.occupancy);
        end
        drain();
    endtask

    task automatic test_illegal();
        bundle_t want;
        want = '{pc: 32'h700, typ: 2'b01, op: 6'h3F, funct: 6'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0,
                 shamt: 5'd0, imm: 32'd0, j_addr: 26'd0, illegal: 1'b1};
        drive(1'b1, 32'hFC00_0000, 32'h700, 1'b1, 1'b0);
        tick();
        checks++;
        if (!bus.out_valid || dut_bundle() !== want) begin
            errors++;
            $display("FAIL illegal valid=%b got %h want %h", bus.out_valid, dut_bundle(), want);
        end
        drain();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rand_inst(), 32'h800 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (dut_status() !== status_t'{valid: 1'b0, in_ready: 1'b1, occ: 3'd0} || dut_bundle() !== bundle_t'('0)) begin
            errors++;
            $display("FAIL async_reset got %h payload %h want 0 payload", dut_status(), dut_bundle());
        end
        pending.delete();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] pc;
        pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(3) != 0), rand_inst(), pc, 1'($urandom_range(2) != 0),
                  1'($urandom_range(40) == 0));
            if (bus.in_valid) pc += 4;
            tick();
            checks++;
            if (dut_status() !== exp_status() ||
                (pending.size() > 0 && dut_bundle() !== ref_decode(pending[0]))) begin
                errors++;
                $display("FAIL random[%0d] status %h want %h bundle %h", i, dut_status(), exp_status(), dut_bundle());
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_imm_ext();
        test_back_pressure();
        test_push_pop_wrap();
        test_flush();
        test_illegal();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decode_queue_stage.md
Name: decode_queue_stage

Overview:
- Successor to the combinational MIPS32 instruction decoder. Buffers fetched instructions in a parametrised FIFO, decodes the head, and presents a registered decode bundle to EX over a valid/ready handshake.
- Adds, relative to the combinational decoder: queue depth, back-pressure, pipeline flush, illegal-opcode detection, and correct per-opcode immediate extension (zero-extend for logical ops, LUI shift).
- Sits between IF and EX in the pipelined core.

Parameters:
- W, 32, datapath/instruction/PC width.
- DEPTH, 4, FIFO entries (power of two, ≥2).
- CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush (branch mispredict/exception).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept.
- in_inst  in  W  raw instruction.
- in_pc  in  W  PC of in_inst.
- out_valid  out  1  decode bundle valid.
- out_ready  in  1  EX accepts bundle.
- out_pc  out  W  PC of decoded instruction.
- out_inst_type  out  2  R/I/J type code.
- out_op_code  out  6  inst[31:26].
- out_funct  out  6  inst[5:0] for R-type, else 0.
- out_rs, out_rt, out_rd  out  5 each  register fields. rd is 0 unless R-type. rs/rt are 0 for J-type.
- out_shamt  out  5  inst[10:6] for R-type, else 0.
- out_imm  out  W  extended immediate.
- out_j_addr  out  26  inst[25:0] for J-type, else 0.
- out_illegal  out  1  opcode not supported.
- occupancy  out  CNT_W  FIFO entries held (excludes output register).

Behaviour:
- Reset (rst=0, async): FIFO pointers and occupancy = 0; out_valid = 0; all out_* payload = 0. in_ready = 1 while in reset.
- in_ready = (occupancy < DEPTH). It has no combinational dependence on out_ready.
- Accept: in_valid && in_ready at a rising edge.
- Output register load condition: load = !out_valid || out_ready.
- Load source:
  - occupancy > 0: FIFO head (pop).
  - else, an accepted input: bypass straight into the output register, not written into the FIFO.
  - When loading from the FIFO head, an accepted input is pushed in the same cycle.
- Program order is always preserved.
- Latency: empty queue + load allowed → instruction accepted at edge N has out_valid = 1 after edge N. Throughput: 1 instruction/cycle.
- out_valid after an edge = load ? (source present) : out_valid. Payload holds while out_valid && !out_ready.
- Full (occupancy = DEPTH): in_ready = 0 even if a pop occurs that cycle.
- Push+pop in the same cycle: occupancy unchanged; pointers wrap modulo DEPTH.
- Flush (sampled at edge): occupancy, pointers = 0; out_valid = 0; any in_valid that cycle is dropped. Flush overrides load and accept. Payload is not cleared.
- Type decode:
  - op 000000 → R (00).
  - 000010/000011 → J (10).
  - Otherwise → I (01).
- Immediate, by opcode:
  - ADDI 001000, ADDIU 001001, SLTI 001010, SLTIU 001011, LW 100011, SW 101011, BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111, REGIMM 000001: sign-extend inst[15:0].
  - ANDI 001100, ORI 001101, XORI 001110: zero-extend.
  - LUI 001111: {inst[15:0],16'b0}.
  - R/J/other: imm = 0.
- out_illegal = 1 for any opcode not in the I-list above, and not R (000000), J, or JAL. Illegal instructions still flow through with imm = 0.

Test Plan:
- Reset then single push: in_inst=0x2008FFFF (ADDI), pc=0x100, out_ready=1 → out_valid after next edge; rs=0, rt=8, imm=0xFFFFFFFF, type=01, illegal=0, occupancy=0.
- Immediate extension: ORI 0x3508FFFF → imm=0x0000FFFF; LUI 0x3C011234 → imm=0x12340000; J 0x08000040 → type=10, j_addr=0x40, imm=0.
- Back-pressure: out_ready=0, push 5 instructions with DEPTH=4 → first in out reg, occupancy=4, in_ready=0. Release out_ready → 5 bundles emerge in order over 5 cycles, PCs increasing.
- Simultaneous push/pop at occupancy=2 for 10 cycles → occupancy stays 2, order intact across pointer wrap.
- Flush with occupancy=3, out_valid=1, in_valid=1 → after edge occupancy=0, out_valid=0, in_ready=1. The next pushed instruction is the first output.
- Illegal opcode 0xFC000000 → illegal=1, imm=0. Async reset asserted mid-stall → out_valid=0 immediately, occupancy=0 without a clock edge.
